// File: rtl/pll_ctrl_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the PLL reset sequencer: state encoding and default
// timing constants.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_t;

  localparam int DEF_RST_HOLD_CYCLES = 10;
  localparam int DEF_LOCK_TIMEOUT    = 5000;
  localparam int DEF_LOCK_STABLE     = 256;
  localparam int DEF_MAX_RETRY       = 3;
  localparam int DEF_CNT_W           = 16;

endpackage

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
// 1-bit two-flop synchronizer; both stages clear on synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_ctrl.sv
`timescale 1ns/1ps
// PLL start-up sequencer: pulses the PLL reset, waits for a debounced lock,
// releases sys_rst, retries a bounded number of times and latches failure.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// HOLD      | pll_areset asserted for RST_HOLD_CYCLES
// WAIT_LOCK | PLL running, waiting up to LOCK_TIMEOUT for locked_s
// STABLE    | locked_s seen; must stay high LOCK_STABLE cycles
// RUN       | downstream reset released, ready high
// FAIL      | retries exhausted; PLL held in reset until areset
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE     = DEF_LOCK_STABLE,
  parameter int MAX_RETRY       = DEF_MAX_RETRY,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       locked,
  output logic       pll_areset,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic       lost_lock,
  output logic [3:0] retry_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [3:0]       RETRY_LAST   = 4'(MAX_RETRY);

  pll_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       retry_nxt;
  logic             lost_nxt;
  logic             locked_s;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (areset),
    .d   (locked),
    .q   (locked_s)
  );

  // cnt restarts on every state change, including re-entry via a retry
  always_ff @(posedge clk) begin
    if (areset) begin
      state     <= ST_HOLD;
      cnt       <= '0;
      retry_cnt <= '0;
      lost_lock <= 1'b0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      lost_lock <= lost_nxt;
      cnt       <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    retry_nxt  = retry_cnt;
    lost_nxt   = lost_lock;
    pll_areset = 1'b1;
    sys_rst    = 1'b1;
    ready      = 1'b0;
    fail       = 1'b0;

    case (state)
      ST_HOLD: begin
        if (cnt == HOLD_LAST) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        pll_areset = 1'b0;
        if (locked_s) begin
          state_nxt = ST_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retry_cnt == RETRY_LAST) begin
            state_nxt = ST_FAIL;
          end else begin
            retry_nxt = retry_cnt + 4'd1;
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_STABLE: begin
        pll_areset = 1'b0;
        // a dropout outranks the terminal count in the same cycle
        if (!locked_s) begin
          state_nxt = ST_WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = ST_RUN;
          retry_nxt = 4'd0;
        end
      end
      ST_RUN: begin
        pll_areset = 1'b0;
        sys_rst    = 1'b0;
        ready      = 1'b1;
        if (!locked_s) begin
          lost_nxt  = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_FAIL: begin
        fail = 1'b1;
      end
      default: begin
        state_nxt = ST_HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for pll_reset_ctrl: directed scenarios plus random lock
// times, checked each cycle against an arithmetic model of the attempt timeline.
module tb_pll_reset_ctrl;

  localparam int RH      = 4;
  localparam int LT      = 20;
  localparam int LS      = 8;
  localparam int MR      = 2;
  localparam int ATT     = RH + LT;
  localparam int FAIL_AT = (MR + 1) * ATT;
  localparam int NEVER   = 100000;

  logic       clk    = 1'b0;
  logic       areset = 1'b1;
  logic       locked = 1'b0;
  logic       pll_areset, sys_rst, ready, fail, lost_lock;
  logic [3:0] retry_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int t        = 0;

  pll_reset_ctrl #(
    .RST_HOLD_CYCLES (RH),
    .LOCK_TIMEOUT    (LT),
    .LOCK_STABLE     (LS),
    .MAX_RETRY       (MR),
    .CNT_W           (16)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .locked     (locked),
    .pll_areset (pll_areset),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fail       (fail),
    .lost_lock  (lost_lock),
    .retry_cnt  (retry_cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp_v);
    end
  endtask

  // outputs are sampled at the falling edge, t counts rising edges since release
  task automatic tick();
    @(negedge clk);
    t++;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    locked = 1'b0;
    @(negedge clk);
    chk("rst_pll_areset", {3'b000, pll_areset}, 4'd1);
    chk("rst_sys_rst",    {3'b000, sys_rst},    4'd1);
    chk("rst_ready",      {3'b000, ready},      4'd0);
    chk("rst_fail",       {3'b000, fail},       4'd0);
    chk("rst_lost_lock",  {3'b000, lost_lock},  4'd0);
    chk("rst_retry_cnt",  retry_cnt,            4'd0);
    areset = 1'b0;
    t = 0;
  endtask

  // Attempts start at origin o and repeat every ATT cycles (RH of PLL reset,
  // then LT of waiting). A lock rising after edge lk is seen by the FSM at lk+3;
  // it counts for the first attempt whose wait window has not yet expired, and
  // if that lands in the attempt's reset phase STABLE starts one cycle into the wait.
  function automatic void predict(input int o, input int lk,
                                  output int s, output int r, output int k,
                                  output bit fl);
    int seen;
    int first_wait;
    seen = lk + 3 - o;
    k = 0;
    while (k <= MR && seen > ATT * k + ATT) k++;
    fl = (k > MR);
    if (fl) begin
      s = NEVER;
      r = NEVER;
      k = MR;
    end else begin
      first_wait = ATT * k + RH + 1;
      s = o + ((seen > first_wait) ? seen : first_wait);
      r = s + LS;
    end
  endfunction

  task automatic chk_model(input int o, input int s, input int r, input int k,
                           input bit fl, input logic lost_e);
    int   rel;
    int   rq;
    logic e_rdy, e_fail, e_pll;
    rel    = t - o;
    e_rdy  = (t >= r);
    e_fail = fl && (rel >= FAIL_AT);
    e_pll  = e_fail || ((t < s) && (rel < FAIL_AT) && ((rel % ATT) < RH));
    if (e_rdy)      rq = 0;
    else if (t < s) rq = (rel / ATT > MR) ? MR : rel / ATT;
    else            rq = k;
    chk("ready",      {3'b000, ready},      {3'b000, e_rdy});
    chk("sys_rst",    {3'b000, sys_rst},    {3'b000, ~e_rdy});
    chk("fail",       {3'b000, fail},       {3'b000, e_fail});
    chk("pll_areset", {3'b000, pll_areset}, {3'b000, e_pll});
    chk("lost_lock",  {3'b000, lost_lock},  {3'b000, lost_e});
    chk("retry_cnt",  retry_cnt,            4'(rq));
  endtask

  // locked rises after edge lk (relative to reset release) and stays high
  task automatic run_check(input int lk, input int n);
    int s, r, k;
    bit fl;
    predict(0, lk, s, r, k, fl);
    if (lk == 0) locked = 1'b1;
    repeat (n) begin
      tick();
      chk_model(0, s, r, k, fl, 1'b0);
      if (t == lk) locked = 1'b1;
    end
  endtask

  initial begin
    int s, r, k, d, d2, e, w, g, l2;
    bit fl;

    repeat (4) @(negedge clk);
    do_reset();

    // nominal: lock 10 cycles after pll_areset falls, RUN 11 cycles later
    run_check(14, 30);

    // lock drop in RUN, then relock with lost_lock sticky
    d  = t + int'($urandom_range(1, 4));
    d2 = d + int'($urandom_range(5, 20));
    predict(d + 3, d2, s, r, k, fl);
    while (t < d2 + 14) begin
      tick();
      if (t < d + 3) begin
        chk("run_ready", {3'b000, ready},     4'd1);
        chk("run_lost",  {3'b000, lost_lock}, 4'd0);
      end else begin
        chk_model(d + 3, s, r, k, fl, 1'b1);
      end
      if (t == d)  locked = 1'b0;
      if (t == d2) locked = 1'b1;
    end

    // permanent loss from RUN runs out of retries into FAIL
    e = t + 2;
    predict(e + 3, NEVER, s, r, k, fl);
    while (t < e + 3 + FAIL_AT + 3) begin
      tick();
      if (t < e + 3) begin
        chk("run2_ready", {3'b000, ready},     4'd1);
        chk("run2_lost",  {3'b000, lost_lock}, 4'd1);
      end else begin
        chk_model(e + 3, s, r, k, fl, 1'b1);
      end
      if (t == e) locked = 1'b0;
    end
    do_reset();

    // locked never rises: FAIL after three attempts
    run_check(NEVER, 90);
    do_reset();

    // short lock pulse during STABLE, then a steady lock later
    w  = int'($urandom_range(2, 6));
    g  = int'($urandom_range(0, 10));
    l2 = 9 + w + g;
    while (t < l2 + 14) begin
      tick();
      chk("glitch_ready",      {3'b000, ready},      {3'b000, 1'(t >= l2 + 11)});
      chk("glitch_sys_rst",    {3'b000, sys_rst},    {3'b000, 1'(t < l2 + 11)});
      chk("glitch_pll_areset", {3'b000, pll_areset}, {3'b000, 1'(t < RH)});
      chk("glitch_retry_cnt",  retry_cnt,            4'd0);
      if (t == 6)     locked = 1'b1;
      if (t == 6 + w) locked = 1'b0;
      if (t == l2)    locked = 1'b1;
    end
    do_reset();

    // areset while in STABLE
    run_check(14, 20);
    do_reset();

    repeat (8) begin
      run_check(int'($urandom_range(0, 80)), 95);
      do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
